// File: rtl/fpu_pkg.sv
// Shared constants and types for the floating-point add/subtract pipeline.
package fpu_pkg;

  localparam int unsigned FPU_EXP_W  = 8;
  localparam int unsigned FPU_MAN_W  = 23;
  localparam int unsigned FPU_STAGES = 4;

  localparam logic [31:0] FPU_QNAN32 = 32'h7FC0_0000;

  // Result class carried down the pipeline alongside the numeric datapath.
  typedef enum logic [1:0] {
    CLS_NUM = 2'd0,
    CLS_INF = 2'd1,
    CLS_NAN = 2'd2
  } res_cls_e;

  // Canonical quiet NaN for an arbitrary format: sign 0, exponent all-ones,
  // mantissa MSB set, everything else clear. Callers slice the low bits.
  function automatic logic [63:0] fpu_qnan(input int unsigned exp_w,
                                           input int unsigned man_w);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
    r[man_w - 1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fpu_lzc #(
  parameter int unsigned WIDTH = 27
) (
  input  logic [WIDTH-1:0]         din,
  output logic [$clog2(WIDTH+1)-1:0] cnt
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  // Scan upward so the highest set bit is the last to write the count.
  always_comb begin
    cnt = CW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (din[i]) cnt = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_addsub.sv
// Four-stage floating-point adder/subtractor: align, add, normalise,
// round/pack. Valid/ready handshake on both sides, one beat per cycle.
module fpu_addsub
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = FPU_EXP_W,
  parameter int unsigned MAN_W = FPU_MAN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   x1,
  input  logic [EXP_W+MAN_W:0]   x2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   y,
  output logic                   ovf,
  output logic                   nv
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned N  = MAN_W + 4;          // hidden + mantissa + G/R/S
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned EW = EXP_W + 2;          // headroom for carry/borrow
  localparam logic [W-1:0] QNAN = W'(fpu_qnan(EXP_W, MAN_W));
  localparam logic [EW-1:0] EXP_MAX = EW'({EXP_W{1'b1}});

  // ---------------- pipeline control ----------------
  logic [FPU_STAGES-1:0] v;
  logic ld1, ld2, ld3, ld4;

  assign ld4      = !v[3] || out_ready;
  assign ld3      = !v[2] || ld4;
  assign ld2      = !v[1] || ld3;
  assign ld1      = !v[0] || ld2;
  assign in_ready = ld1;

  // Stage valid bits: each stage takes its predecessor's valid when it loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
    end else begin
      if (ld1) v[0] <= in_valid;
      if (ld2) v[1] <= v[0];
      if (ld3) v[2] <= v[1];
      if (ld4) v[3] <= v[2];
    end
  end

  // ---------------- stage 1: unpack, classify, align ----------------
  logic              sa, sb;
  logic [EXP_W-1:0]  ea, eb;
  logic [MAN_W-1:0]  ma, mb;
  logic              a_nan, b_nan, a_inf, b_inf;
  logic [EXP_W-1:0]  big_e, sml_e, d;
  logic [MAN_W-1:0]  big_m, sml_m;
  logic              big_s;
  logic [N-1:0]      ext_s, sh, lost;
  logic [N-1:0]      c1_big, c1_sml;
  res_cls_e          c1_cls;
  logic              c1_ssign;

  // Operand decode, special-case detection and alignment of the smaller one.
  always_comb begin
    sa = x1[W-1];
    ea = x1[W-2:MAN_W];
    ma = x1[MAN_W-1:0];
    sb = x2[W-1] ^ op;
    eb = x2[W-2:MAN_W];
    mb = x2[MAN_W-1:0];

    a_nan = (&ea) && (|ma);
    b_nan = (&eb) && (|mb);
    a_inf = (&ea) && !(|ma);
    b_inf = (&eb) && !(|mb);

    // Subnormals become signed zeros before any magnitude work.
    if (ea == '0) ma = '0;
    if (eb == '0) mb = '0;

    if ({ea, ma} >= {eb, mb}) begin
      big_e = ea; big_m = ma; big_s = sa;
      sml_e = eb; sml_m = mb;
    end else begin
      big_e = eb; big_m = mb; big_s = sb;
      sml_e = ea; sml_m = ma;
    end

    d      = big_e - sml_e;
    c1_big = {|big_e, big_m, 3'b000};
    ext_s  = {|sml_e, sml_m, 3'b000};
    sh     = ext_s >> d;
    lost   = ext_s & ((N'(1) << d) - N'(1));
    if (32'(d) >= MAN_W + 3) c1_sml = {{(N-1){1'b0}}, |ext_s};
    else                     c1_sml = sh | {{(N-1){1'b0}}, |lost};

    c1_cls   = CLS_NUM;
    c1_ssign = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      c1_cls = CLS_NAN;
    end else if (a_inf || b_inf) begin
      c1_cls   = CLS_INF;
      c1_ssign = a_inf ? sa : sb;
    end
  end

  logic [N-1:0]     r1_big, r1_sml;
  logic [EXP_W-1:0] r1_exp;
  logic             r1_sign, r1_sub, r1_zneg, r1_ssign;
  res_cls_e         r1_cls;

  // ---------------- stage 2: magnitude add/subtract ----------------
  logic [N:0] c2_sum;

  // Operands are ordered by magnitude, so the difference never goes negative.
  always_comb begin
    if (r1_sub) c2_sum = {1'b0, r1_big} - {1'b0, r1_sml};
    else        c2_sum = {1'b0, r1_big} + {1'b0, r1_sml};
  end

  logic [N:0]       r2_sum;
  logic [EXP_W-1:0] r2_exp;
  logic             r2_sign, r2_zneg, r2_ssign;
  res_cls_e         r2_cls;

  // ---------------- stage 3: normalise ----------------
  logic [CW-1:0] lz;
  logic [N-1:0]  c3_man;
  logic [EW-1:0] c3_exp;
  logic          c3_zero;

  fpu_lzc #(.WIDTH(N)) u_lzc (
    .din (r2_sum[N-1:0]),
    .cnt (lz)
  );

  // Carry-out shifts right (keeping sticky); otherwise shift left by the
  // leading-zero count, flushing anything that would go subnormal.
  always_comb begin
    c3_man  = '0;
    c3_exp  = '0;
    c3_zero = 1'b0;
    if (r2_sum[N]) begin
      c3_man = {r2_sum[N:2], r2_sum[1] | r2_sum[0]};
      c3_exp = EW'(r2_exp) + EW'(1);
    end else if (r2_sum[N-1:0] == '0) begin
      c3_zero = 1'b1;
    end else if (EW'(r2_exp) <= EW'(lz)) begin
      c3_zero = 1'b1;
    end else begin
      c3_man = r2_sum[N-1:0] << lz;
      c3_exp = EW'(r2_exp) - EW'(lz);
    end
  end

  logic [N-1:0]  r3_man;
  logic [EW-1:0] r3_exp;
  logic          r3_zero, r3_sign, r3_zneg, r3_ssign;
  res_cls_e      r3_cls;

  // ---------------- stage 4: round and pack ----------------
  logic             rnd;
  logic [MAN_W+1:0] mr;
  logic [EW-1:0]    e_f;
  logic [MAN_W-1:0] frac;
  logic [W-1:0]     c4_y;
  logic             c4_ovf, c4_nv;

  // Round to nearest even, then handle overflow and special classes.
  always_comb begin
    rnd  = r3_man[2] & (r3_man[1] | r3_man[0] | r3_man[3]);
    mr   = {1'b0, r3_man[N-1:3]} + (MAN_W+2)'(rnd);
    e_f  = r3_exp + EW'(mr[MAN_W+1]);
    frac = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];

    c4_y   = '0;
    c4_ovf = 1'b0;
    c4_nv  = 1'b0;
    case (r3_cls)
      CLS_NAN: begin
        c4_y  = QNAN;
        c4_nv = 1'b1;
      end
      CLS_INF: c4_y = {r3_ssign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      default: begin
        if (r3_zero) begin
          c4_y = {r3_zneg, {(W-1){1'b0}}};
        end else if (e_f >= EXP_MAX) begin
          c4_y   = {r3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          c4_ovf = 1'b1;
        end else begin
          c4_y = {r3_sign, e_f[EXP_W-1:0], frac};
        end
      end
    endcase
  end

  // Datapath registers: no reset, qualified only by the stage load enables.
  always_ff @(posedge clk) begin
    if (ld1) begin
      r1_big   <= c1_big;
      r1_sml   <= c1_sml;
      r1_exp   <= big_e;
      r1_sign  <= big_s;
      r1_sub   <= sa ^ sb;
      r1_zneg  <= sa & sb;
      r1_cls   <= c1_cls;
      r1_ssign <= c1_ssign;
    end
    if (ld2) begin
      r2_sum   <= c2_sum;
      r2_exp   <= r1_exp;
      r2_sign  <= r1_sign;
      r2_zneg  <= r1_zneg;
      r2_cls   <= r1_cls;
      r2_ssign <= r1_ssign;
    end
    if (ld3) begin
      r3_man   <= c3_man;
      r3_exp   <= c3_exp;
      r3_zero  <= c3_zero;
      r3_sign  <= r2_sign;
      r3_zneg  <= r2_zneg;
      r3_cls   <= r2_cls;
      r3_ssign <= r2_ssign;
    end
  end

  logic [W-1:0] y_q;
  logic         ovf_q, nv_q;

  // Output register holds its beat until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= '0;
      ovf_q <= 1'b0;
      nv_q  <= 1'b0;
    end else if (ld4 && v[2]) begin
      y_q   <= c4_y;
      ovf_q <= c4_ovf;
      nv_q  <= c4_nv;
    end
  end

  assign out_valid = v[3];
  assign y         = y_q;
  assign ovf       = v[3] & ovf_q;
  assign nv        = v[3] & nv_q;

endmodule

// File: tb/tb_fpu_addsub.sv
// Directed bench for fpu_addsub: vector table, stall, reset, half precision.
module tb_fpu_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // single-precision instance
  logic        in_valid_s = 1'b0, in_ready_s, op_s = 1'b0;
  logic [31:0] x1_s = '0, x2_s = '0, y_s;
  logic        out_valid_s, out_ready_s = 1'b1, ovf_s, nv_s;

  // half-precision instance
  logic        in_valid_h = 1'b0, in_ready_h, op_h = 1'b0;
  logic [15:0] x1_h = '0, x2_h = '0, y_h;
  logic        out_valid_h, out_ready_h = 1'b1, ovf_h, nv_h;

  fpu_addsub #(.EXP_W(8), .MAN_W(23)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .op(op_s), .x1(x1_s), .x2(x2_s), .out_valid(out_valid_s),
    .out_ready(out_ready_s), .y(y_s), .ovf(ovf_s), .nv(nv_s)
  );

  fpu_addsub #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(in_valid_h), .in_ready(in_ready_h),
    .op(op_h), .x1(x1_h), .x2(x2_h), .out_valid(out_valid_h),
    .out_ready(out_ready_h), .y(y_h), .ovf(ovf_h), .nv(nv_h)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        ovf;
    logic        nv;
  } vec_t;

  localparam int NVEC = 19;
  vec_t tbl [NVEC];

  // One beat through an empty pipeline with out_ready high; checks latency,
  // result flags, and that ovf/nv stay low while out_valid is low.
  task automatic run_vec(input string nm, input logic op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ey,
                         input logic eovf, input logic env);
    int lat;
    logic [31:0] gy;
    logic gov, gnv, side;
    lat = 0; gy = '0; gov = 1'b0; gnv = 1'b0; side = 1'b0;
    @(negedge clk);
    op_s = op; x1_s = a; x2_s = b; in_valid_s = 1'b1; out_ready_s = 1'b1;
    #1 chk({nm, "/in_ready"}, 64'(in_ready_s), 64'd1);
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) in_valid_s = 1'b0;
      #1;
      if (!out_valid_s && (ovf_s || nv_s)) side = 1'b1;
      if (out_valid_s && lat == 0) begin
        lat = k; gy = y_s; gov = ovf_s; gnv = nv_s;
      end
    end
    chk({nm, "/latency"}, 64'(lat), 64'd4);
    chk({nm, "/y"}, 64'(gy), 64'(ey));
    chk({nm, "/ovf"}, 64'(gov), 64'(eovf));
    chk({nm, "/nv"}, 64'(gnv), 64'(env));
    chk({nm, "/flags_idle"}, 64'(side), 64'd0);
  endtask

  logic [31:0] st_b [8];
  logic [31:0] st_y [8];

  initial begin
    tbl[0]  = '{1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 32'h3F800000, 32'h33C00000, 32'h3F800001, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 32'h40000000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 32'hBF800000, 32'hBF800000, 32'hC0000000, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 32'h3FC00000, 32'h40200000, 32'h40800000, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 32'h7FC12345, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 32'h00800001, 32'h80800000, 32'h00000000, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0, 1'b0};

    // 1.0 + i for i = 0..7
    st_b = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
             32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};
    st_y = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst/out_valid", 64'(out_valid_s), 64'd0);
    chk("rst/y", 64'(y_s), 64'd0);
    chk("rst/ovf", 64'(ovf_s), 64'd0);
    chk("rst/nv", 64'(nv_s), 64'd0);
    rst = 1'b0;

    // ---- vector table ----
    for (int i = 0; i < NVEC; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
              tbl[i].y, tbl[i].ovf, tbl[i].nv);
    end

    // ---- 8 back-to-back beats, out_ready low in cycles 3..6 ----
    begin
      int ib, ob;
      logic held;
      logic [31:0] held_y;
      ib = 0; ob = 0; held = 1'b0; held_y = '0;
      for (int cyc = 0; cyc < 30; cyc++) begin
        @(negedge clk);
        op_s = 1'b0;
        x1_s = 32'h3F800000;
        if (ib < 8) begin
          in_valid_s = 1'b1;
          x2_s = st_b[ib];
        end else begin
          in_valid_s = 1'b0;
        end
        out_ready_s = !(cyc >= 3 && cyc <= 6);
        #1;
        if (held) begin
          chk("stall/hold_valid", 64'(out_valid_s), 64'd1);
          chk("stall/hold_y", 64'(y_s), 64'(held_y));
        end
        if (out_valid_s && out_ready_s) begin
          if (ob < 8) chk($sformatf("stall/y%0d", ob), 64'(y_s), 64'(st_y[ob]));
          else chk("stall/extra_beat", 64'd1, 64'd0);
          ob++;
        end
        held   = out_valid_s && !out_ready_s;
        held_y = y_s;
        if (in_valid_s && in_ready_s) ib++;
      end
      chk("stall/accepted", 64'(ib), 64'd8);
      chk("stall/delivered", 64'(ob), 64'd8);
    end

    // ---- reset with three beats in flight ----
    begin
      int stale;
      stale = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        in_valid_s = 1'b1; op_s = 1'b0; x1_s = 32'h3F800000; x2_s = st_b[k+1];
        out_ready_s = 1'b1;
      end
      @(negedge clk);
      in_valid_s = 1'b0; out_ready_s = 1'b0;
      @(negedge clk); #1;
      chk("mrst/pre_valid", 64'(out_valid_s), 64'd1);
      rst = 1'b1;
      #1;
      chk("mrst/out_valid", 64'(out_valid_s), 64'd0);
      chk("mrst/y", 64'(y_s), 64'd0);
      chk("mrst/ovf_nv", 64'({ovf_s, nv_s}), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      out_ready_s = 1'b1;
      #1 chk("mrst/in_ready", 64'(in_ready_s), 64'd1);
      for (int k = 0; k < 6; k++) begin
        @(negedge clk); #1;
        if (out_valid_s) stale++;
      end
      chk("mrst/stale", 64'(stale), 64'd0);
      run_vec("mrst/next", 1'b0, 32'h3FC00000, 32'h40200000, 32'h40800000, 1'b0, 1'b0);
    end

    // ---- half precision: 1.0 + 1.0 ----
    begin
      int lat;
      logic [15:0] gy;
      lat = 0; gy = '0;
      @(negedge clk);
      in_valid_h = 1'b1; op_h = 1'b0; x1_h = 16'h3C00; x2_h = 16'h3C00; out_ready_h = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (k == 1) in_valid_h = 1'b0;
        #1;
        if (out_valid_h && lat == 0) begin
          lat = k; gy = y_h;
        end
      end
      chk("half/latency", 64'(lat), 64'd4);
      chk("half/y", 64'(gy), 64'h4000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_addsub.md
FPU_ADDSUB -- requirements
Module: fpu_addsub

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa field width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, operand beat present.
REQ-006 SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-007 SHALL have port op, input, 1, 0 = x1+x2, 1 = x1-x2.
REQ-008 SHALL have ports x1 and x2, input, W, IEEE-style operands.
REQ-009 SHALL have port out_valid, output, 1, result beat present.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port y, output, W, result.
REQ-012 SHALL have port ovf, output, 1, finite operands produced infinity.
REQ-013 SHALL have port nv, output, 1, invalid operation (NaN in, or inf-inf).

Function
REQ-014 SHALL transfer an input beat when in_valid && in_ready, and an output beat when out_valid && out_ready.
REQ-015 SHALL be a 4-stage pipeline (align, add, normalise, round/pack); with out_ready held high, y appears exactly 4 cycles after acceptance.
REQ-016 SHALL sustain one beat per cycle with no bubbles while out_ready is high.
REQ-017 SHALL give each stage a valid bit; a stage loads when empty or when its successor loads; in_ready = !v1 || stage 1 advances (no combinational path from in_valid to in_ready).
REQ-018 SHALL hold y/ovf/nv/out_valid stable while out_valid && !out_ready; no beat is dropped or duplicated; order is preserved.
REQ-019 SHALL apply op by inverting the sign of x2 before magnitude compare.
REQ-020 SHALL flush subnormal inputs to signed zero and flush subnormal results to +0 (or -0 when both effective signs negative).
REQ-021 SHALL align the smaller operand with guard, round and sticky bits; shift >= MAN_W+3 leaves only sticky.
REQ-022 SHALL normalise with leading-zero count over MAN_W+4 bits; exact zero difference yields +0.
REQ-023 SHALL round to nearest, ties to even; mantissa carry-out increments the exponent.
REQ-024 SHALL return +inf/-inf with ovf=1 when the rounded exponent reaches all-ones from finite operands.
REQ-025 SHALL return infinity (ovf=0) when exactly one operand is infinite, or both infinite with equal effective sign.
REQ-026 SHALL return canonical quiet NaN (sign 0, exponent all-ones, mantissa MSB 1, rest 0) with nv=1 for any NaN input or inf-inf.
REQ-027 SHALL drive ovf and nv low whenever out_valid is low.

Reset
REQ-028 SHALL, on rst assertion, clear all stage valid bits immediately; out_valid=0, y=0, ovf=0, nv=0.
REQ-029 SHALL discard in-flight beats on mid-operation reset; in_ready=1 in the first cycle after rst deasserts.
REQ-030 SHALL reset only control and output registers; datapath registers need not be reset.

Structure
REQ-031 SHALL place default widths, the canonical NaN constant and stage-count constant in shared package fpu_pkg.
REQ-032 SHALL instantiate one parametrised sub-module fpu_lzc (leading-zero counter, width parameter) in the normalise stage.

Verification
REQ-033 SHALL check op=0, x1=0x3F800000, x2=0x3F800000 -> y=0x40000000 exactly 4 cycles later, ovf=0, nv=0.
REQ-034 SHALL check op=1, x1=x2=0x3F800000 -> y=0x00000000; op=0, x1=0x3F800000, x2=0x33800000 -> 0x3F800000 (tie to even); x2=0x33C00000 -> 0x3F800001.
REQ-035 SHALL check 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, ovf=1; 0x7F800000 + 0xFF800000 -> 0x7FC00000, nv=1.
REQ-036 SHALL drive 8 back-to-back beats with out_ready low for cycles 3-6 -> all 8 results in order, none lost, y stable while stalled.
REQ-037 SHALL assert rst with 3 beats in flight -> out_valid=0 immediately, no stale beat emerges after release, next beat correct after 4 cycles.
REQ-038 SHALL rerun REQ-033 at EXP_W=5, MAN_W=10: 0x3C00+0x3C00 -> 0x4000.
